demux_nway_reg_chip: RTL and testbench

- Registered, parametrised N-way demultiplexer with a valid/ready handshake per channel.
- Routes WIDTH-bit words from one input stream to one of N output channels. A broadcast mode routes a word to all channels at once.
- Each output channel has a one-entry holding register, so back-pressure on one channel does not block traffic to the others.
- Sits between the CPU-side producer and per-device sinks in the chips library. It supersedes the combinational 1-bit demux wherever sinks can stall.

---
 rtl/demux_nway_reg_chip.sv | 123 ++++++++++++
 tb/tb_demux_nway_reg_chip.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_nway_reg_chip.sv
`default_nettype none
// ============================================================================
// Module      : demux_nway_reg_chip
// Description : Registered N-way demultiplexer with a valid/ready handshake
//               on every channel. Each input word goes to the channel named
//               by in_sel, or to all channels when in_bcast is high. Every
//               output channel has a one-entry holding register, so a stalled
//               sink does not block traffic to the other channels. A word
//               whose select is out of range is accepted and then discarded.
//               Each discard is counted by a saturating counter.
// Ports       : clk, reset      - rising-edge clock; synchronous active-high
//                                  reset
//               in_valid/ready  - input handshake
//               in_data         - input word (WIDTH bits)
//               in_sel          - destination channel index (SELW bits)
//               in_bcast        - write the word to all N channels
//               out_valid/ready - per-channel handshake (N bits each)
//               out_data        - channel k is at [k*WIDTH +: WIDTH]
//               drop            - one-cycle pulse after a discarded word
//               drop_count      - saturating 8-bit count of discarded words
// Revision    : 1.0 - initial release
// ============================================================================
module demux_nway_reg_chip #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int SELW  = 3     // 2**SELW must be >= N
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 in_bcast,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic [N*WIDTH-1:0]   out_data,
    output logic                 drop,
    output logic [7:0]           drop_count
);

    localparam int          C_NPAD   = 2**SELW;
    localparam int unsigned C_N      = N;
    localparam logic [7:0]  C_CNTMAX = 8'hFF;

    logic [N-1:0]      r_valid;
    logic [N-1:0]      w_free;
    logic [C_NPAD-1:0] w_free_pad;
    logic              w_in_range;
    logic              w_accept;
    logic              w_drop_acc;
    logic              r_drop;
    logic [7:0]        r_drop_count;

    // A channel can take a new word if it is empty or is being drained
    // on this edge. Drain and refill on the same edge gives full throughput.
    assign w_free = ~r_valid | out_ready;

    // Widen the free vector to the full select range so that indexing with an
    // out-of-range select stays within the vector.
    always_comb begin
        w_free_pad         = '0;
        w_free_pad[N-1:0]  = w_free;
    end

    assign w_in_range = (32'(in_sel) < C_N);

    always_comb begin
        in_ready = 1'b1;                    // out-of-range words are discarded
        if (in_bcast) begin
            in_ready = &w_free;
        end else if (w_in_range) begin
            in_ready = w_free_pad[in_sel];
        end
    end

    assign w_accept   = in_valid & in_ready;
    assign w_drop_acc = w_accept & ~in_bcast & ~w_in_range;

    generate
        for (genvar k = 0; k < N; k++) begin : g_chan
            logic             w_load;
            logic [WIDTH-1:0] r_data;

            assign w_load = w_accept &
                            (in_bcast | (w_in_range && (in_sel == SELW'(k))));

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid[k] <= 1'b0;
                    r_data     <= '0;
                end else if (w_load) begin
                    r_valid[k] <= 1'b1;
                    r_data     <= in_data;
                end else if (r_valid[k] && out_ready[k]) begin
                    // An empty channel shows zero on its data slice.
                    r_valid[k] <= 1'b0;
                    r_data     <= '0;
                end
            end

            assign out_data[k*WIDTH +: WIDTH] = r_data;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop       <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_drop <= w_drop_acc;
            if (w_drop_acc && (r_drop_count != C_CNTMAX)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign out_valid  = r_valid;
    assign drop       = r_drop;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_demux_nway_reg_chip.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_nway_reg_chip
// Description : Directed testbench for demux_nway_reg_chip. It uses an
//               8-channel instance for routing, back-pressure and broadcast.
//               It uses a 6-channel instance for out-of-range drops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_nway_reg_chip;

    logic         clk = 1'b0;
    logic         reset;

    // 8-channel instance
    logic         in_valid, in_ready, in_bcast, drop, drop_sink_unused;
    logic [15:0]  in_data;
    logic [2:0]   in_sel;
    logic [7:0]   out_valid, out_ready, drop_count;
    logic [127:0] out_data;

    // 6-channel instance
    logic         in_valid6, in_ready6, drop6;
    logic [15:0]  in_data6;
    logic [2:0]   in_sel6;
    logic [5:0]   out_valid6, out_ready6;
    logic [95:0]  out_data6;
    logic [7:0]   drop_count6;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    demux_nway_reg_chip #(.WIDTH(16), .N(8), .SELW(3)) u_dut8 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_bcast   (in_bcast),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop       (drop),
        .drop_count (drop_count)
    );

    demux_nway_reg_chip #(.WIDTH(16), .N(6), .SELW(3)) u_dut6 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid6),
        .in_ready   (in_ready6),
        .in_data    (in_data6),
        .in_sel     (in_sel6),
        .in_bcast   (1'b0),
        .out_valid  (out_valid6),
        .out_ready  (out_ready6),
        .out_data   (out_data6),
        .drop       (drop6),
        .drop_count (drop_count6)
    );

    assign drop_sink_unused = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] exp_bc;

        // ---- reset, with a pending word that must not load ----
        reset     = 1'b1;
        in_valid  = 1'b1;  in_sel  = 3'd3; in_data  = 16'h1234; in_bcast = 1'b0;
        out_ready = 8'h00;
        in_valid6 = 1'b1;  in_sel6 = 3'd7; in_data6 = 16'h5555; out_ready6 = 6'h00;
        step();
        step();
        chk("rst_valid", out_valid, 8'h00);
        chk("rst_data",  out_data, '0);
        chk("rst_dcnt",  drop_count, 8'd0);
        chk("rst_drop",  drop, 1'b0);
        chk("rst_dcnt6", drop_count6, 8'd0);
        chk("rst_drop6", drop6, 1'b0);
        reset = 1'b0; in_valid = 1'b0; in_valid6 = 1'b0;

        // ---- single route to channel 5 ----
        in_data = 16'hBEEF; in_sel = 3'd5; in_valid = 1'b1;
        #1 chk("route_rdy", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("route_valid", out_valid, 8'b0010_0000);
        chk("route_data",  out_data, 128'hBEEF << 80);
        out_ready = 8'b0010_0000;
        step();
        chk("pop_valid", out_valid, 8'h00);
        chk("pop_data",  out_data, '0);
        out_ready = 8'h00;

        // ---- back-pressure on channel 2 ----
        in_data = 16'h1111; in_sel = 3'd2; in_valid = 1'b1;
        step();
        in_data = 16'd1;
        #1 chk("bp_rdy_low", in_ready, 1'b0);
        step();
        chk("bp_held_valid", out_valid, 8'h04);
        chk("bp_held_data",  out_data, 128'h1111 << 32);
        out_ready = 8'h04;
        #1 chk("bp_rdy_high", in_ready, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step();
            in_data = 16'(i + 1);
            chk("stream_valid", out_valid, 8'h04);
            chk("stream_data",  out_data, 128'(i) << 32);
        end
        in_valid = 1'b0;
        step();
        chk("stream_empty", out_valid, 8'h00);
        out_ready = 8'h00;

        // ---- independence: channel 0 stalled, channel 7 still flows ----
        in_data = 16'hAAAA; in_sel = 3'd0; in_valid = 1'b1;
        step();
        in_data = 16'h7777; in_sel = 3'd7;
        #1 chk("indep_rdy", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("indep_valid", out_valid, 8'h81);
        chk("indep_data",  out_data, (128'h7777 << 112) | 128'hAAAA);
        out_ready = 8'hFF;
        step();
        chk("indep_drain", out_valid, 8'h00);
        out_ready = 8'h00;

        // ---- broadcast into empty channels ----
        in_bcast = 1'b1; in_data = 16'h00A5; in_sel = 3'd1; in_valid = 1'b1;
        #1 chk("bc_rdy", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        exp_bc = {8{16'h00A5}};
        chk("bc_valid", out_valid, 8'hFF);
        chk("bc_data",  out_data, exp_bc);
        chk("bc_nodrop", drop, 1'b0);

        // drain every channel but 4, then broadcast with 4 stalled
        out_ready = 8'hEF;
        step();
        chk("bc_part_drain", out_valid, 8'h10);
        out_ready = 8'h00;
        in_data = 16'h5A5A; in_valid = 1'b1;
        #1 chk("bc_block_rdy", in_ready, 1'b0);
        step();
        chk("bc_block_valid", out_valid, 8'h10);
        chk("bc_block_data",  out_data, 128'h00A5 << 64);
        in_valid = 1'b0; in_bcast = 1'b0;

        // ---- drops on the 6-channel instance ----
        in_sel6 = 3'd7; in_data6 = 16'hD00D; in_valid6 = 1'b1;
        #1 chk("drop_rdy", in_ready6, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("drop_pulse", drop6, 1'b1);
            chk("drop_cnt",   drop_count6, 8'(i));
        end
        in_valid6 = 1'b0;
        step();
        chk("drop_end",   drop6, 1'b0);
        chk("drop_cnt3",  drop_count6, 8'd3);
        chk("drop_noval", out_valid6, 6'h00);
        chk("drop_nodat", out_data6, '0);

        // in-range word on the 6-channel instance
        in_sel6 = 3'd5; in_data6 = 16'h6006; in_valid6 = 1'b1;
        step();
        in_valid6 = 1'b0;
        chk("n6_valid", out_valid6, 6'h20);
        chk("n6_data",  out_data6, 96'h6006 << 80);
        chk("n6_nodrop", drop6, 1'b0);

        // saturation: 300 more drops using select 6
        in_sel6 = 3'd6; in_valid6 = 1'b1;
        #1 chk("sat_rdy", in_ready6, 1'b1);
        repeat (300) step();
        in_valid6 = 1'b0;
        step();
        chk("sat_cnt",   drop_count6, 8'd255);
        chk("sat_valid", out_valid6, 6'h20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
